// File: rtl/pc_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the program-counter / branch-resolution stage.
//   - PC_SRC_* codes driven by the instruction decoder
//   - default reset / interrupt / exception vectors
//   - next-PC selection enum used to make the trap priority explicit
//   - target-address helper functions shared by the PC mux
// ---------------------------------------------------------------------------
package cpu_defs;

    // Decoded PC source codes. Any other 3-bit code behaves like SEQ.
    localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
    localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
    localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
    localparam logic [2:0] PC_SRC_JR     = 3'd3;

    // Default vectors. All live in kernel space (bit 31 set).
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h8000_0008;

    // Which source feeds the PC register this cycle, in priority order.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_EXC    = 2'd1,
        SEL_IRQ    = 2'd2,
        SEL_NORMAL = 2'd3
    } next_sel_e;

    // Word-offset branch target relative to the delay-free pc+4.
    // Bit 31 is taken from the current pc so a branch can never cross
    // between user and kernel space.
    function automatic logic [31:0] calc_branch_target(
        input logic [31:0] cur_pc,
        input logic [15:0] imm16
    );
        logic [31:0] offset;
        logic [31:0] target;
        offset = {{14{imm16[15]}}, imm16, 2'b00};
        target = cur_pc + 32'd4 + offset;
        target[31] = cur_pc[31];
        return target;
    endfunction

    // Region-relative jump: the top nibble of the current pc is kept.
    function automatic logic [31:0] calc_jump_target(
        input logic [31:0] cur_pc,
        input logic [25:0] jaddr
    );
        return {cur_pc[31:28], jaddr, 2'b00};
    endfunction

    // Register jump: kernel code may drop to user space, but user code
    // cannot raise bit 31 and so can never jump into kernel space.
    function automatic logic [31:0] calc_jr_target(
        input logic [31:0] cur_pc,
        input logic [31:0] jr_target
    );
        return {jr_target[31] & cur_pc[31], jr_target[30:0]};
    endfunction

endpackage

// File: rtl/pc_branch_unit_irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Brings an asynchronous interrupt level into the clock domain through a
// SYNC_STAGES-deep flop chain, then produces a one-cycle pulse on each
// synchronised rising edge.
// Ports:
//   clk      in  1  system clock, rising edge
//   reset    in  1  asynchronous, active-high reset (clears chain and edge flop)
//   async_in in  1  asynchronous level input
//   rise     out 1  one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_d;

    // Metastability chain: bit 0 samples the raw input, the top bit is the
    // first one safe to use. The extra flop keeps last cycle's synchronised
    // value so a rising edge shows up as top-bit high while sync_d is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            sync_d     <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
            sync_d     <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign rise = sync_chain[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program-counter and branch-resolution stage behind the ALU compare units.
// Chooses the next PC from sequential / branch / jump / register-jump
// sources, and adds trap entry for an illegal opcode and an external,
// edge-latched interrupt. Supervisor mode is pc[31]; interrupts are masked
// while it is set.
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   asynchronous, active-high reset
//   stall      in  1   hold pc this cycle, no trap is taken
//   pc_src     in  3   0=SEQ 1=BRANCH 2=JUMP 3=JR, others as SEQ
//   cmp_result in  1   ALU compare bit, selects branch target when set
//   imm16      in  16  signed branch offset in words
//   jaddr      in  26  J/JAL target field
//   jr_target  in  32  register value for JR/JALR
//   illop      in  1   current instruction is undefined
//   irq        in  1   external interrupt, asynchronous level
//   pc         out 32  current pc (registered)
//   pc_plus4   out 32  pc+4, link value for JAL/JALR
//   epc_we     out 1   write epc this cycle (a trap is being taken)
//   epc        out 32  return address for the trap handler
//   irq_pend   out 1   registered pending-interrupt flag
// ---------------------------------------------------------------------------
module pc_branch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] IRQ_VEC     = DEFAULT_IRQ_VEC,
    parameter logic [31:0] EXC_VEC     = DEFAULT_EXC_VEC,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic        cmp_result,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] jr_target,
    input  logic        illop,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        epc_we,
    output logic [31:0] epc,
    output logic        irq_pend
);

    logic        irq_rise;
    next_sel_e   next_sel;
    logic [31:0] normal_pc;
    logic [31:0] next_pc;

    irq_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(irq),
        .rise    (irq_rise)
    );

    assign pc_plus4 = pc + 32'd4;

    // Trap priority: a stall freezes everything, the illegal-op trap beats a
    // pending interrupt (which then stays pending), and interrupts are only
    // accepted from user mode.
    always_comb begin
        next_sel = SEL_NORMAL;
        if (stall) begin
            next_sel = SEL_HOLD;
        end else if (illop) begin
            next_sel = SEL_EXC;
        end else if (irq_pend && !pc[31]) begin
            next_sel = SEL_IRQ;
        end
    end

    // Ordinary control flow when no trap is taken. Unknown codes fall back
    // to sequential fetch.
    always_comb begin
        normal_pc = pc_plus4;
        case (pc_src)
            PC_SRC_BRANCH: normal_pc = cmp_result ? calc_branch_target(pc, imm16) : pc_plus4;
            PC_SRC_JUMP:   normal_pc = calc_jump_target(pc, jaddr);
            PC_SRC_JR:     normal_pc = calc_jr_target(pc, jr_target);
            default:       normal_pc = pc_plus4;
        endcase
    end

    always_comb begin
        next_pc = normal_pc;
        case (next_sel)
            SEL_HOLD: next_pc = pc;
            SEL_EXC:  next_pc = EXC_VEC;
            SEL_IRQ:  next_pc = IRQ_VEC;
            default:  next_pc = normal_pc;
        endcase
    end

    // An interrupt returns to the interrupted instruction so it re-executes;
    // an illegal op returns past the faulting instruction. While reset is
    // held no trap can be reported.
    assign epc_we = ~reset & ((next_sel == SEL_EXC) | (next_sel == SEL_IRQ));
    assign epc    = (next_sel == SEL_IRQ) ? pc : pc_plus4;

    // PC register and pending latch. A fresh edge arriving in the same cycle
    // the interrupt is taken must not be lost, so set wins over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            irq_pend <= 1'b0;
        end else begin
            pc       <= next_pc;
            irq_pend <= irq_rise | (irq_pend & (next_sel != SEL_IRQ));
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
// Directed bench for pc_branch_unit. A behavioural model tracks pc and the
// pending flag from the architectural rules; a compare process checks every
// output against it on each falling edge, while the directed sequence pins
// the model with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;
    import cpu_defs::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic        cmp_result;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] jr_target;
    logic        illop;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        epc_we;
    logic [31:0] epc;
    logic        irq_pend;

    int checks = 0;
    int errors = 0;

    pc_branch_unit #(
        .RESET_PC   (32'h8000_0000),
        .IRQ_VEC    (32'h8000_0004),
        .EXC_VEC    (32'h8000_0008),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_src    (pc_src),
        .cmp_result(cmp_result),
        .imm16     (imm16),
        .jaddr     (jaddr),
        .jr_target (jr_target),
        .illop     (illop),
        .irq       (irq),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .epc_we    (epc_we),
        .epc       (epc),
        .irq_pend  (irq_pend)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the non-interrupt inputs as one instruction's worth of decode.
    task automatic applyStimulus(input logic s, input logic [2:0] src, input logic cmp,
                                 input logic [15:0] imm, input logic [25:0] ja,
                                 input logic [31:0] jr, input logic ill);
        stall      = s;
        pc_src     = src;
        cmp_result = cmp;
        imm16      = imm;
        jaddr      = ja;
        jr_target  = jr;
        illop      = ill;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_pend;
    bit          irq_hist[$];
    bit          model_ready = 1'b0;

    always @(posedge clk or posedge reset) begin
        int                 n;
        bit                 rise;
        bit                 took_irq;
        logic signed [31:0] off;
        logic [31:0]        t;
        if (reset) begin
            m_pc        = 32'h8000_0000;
            m_pend      = 1'b0;
            irq_hist    = '{0, 0, 0, 0};
            model_ready = 1'b1;
        end else begin
            // irq as seen SYNC edges ago, compared with one edge earlier
            n        = irq_hist.size();
            rise     = irq_hist[n-SYNC] && !irq_hist[n-SYNC-1];
            took_irq = 1'b0;
            if (stall) begin
                m_pc = m_pc;
            end else if (illop) begin
                m_pc = 32'h8000_0008;
            end else if (m_pend && m_pc[31] == 1'b0) begin
                m_pc     = 32'h8000_0004;
                took_irq = 1'b1;
            end else if (pc_src == PC_SRC_BRANCH && cmp_result) begin
                off  = 32'($signed(imm16));
                t    = m_pc + 32'd4 + 32'(off * 4);
                t[31] = m_pc[31];
                m_pc = t;
            end else if (pc_src == PC_SRC_JUMP) begin
                m_pc = (m_pc & 32'hF000_0000) | (32'(jaddr) * 4);
            end else if (pc_src == PC_SRC_JR) begin
                m_pc = m_pc[31] ? jr_target : (jr_target & 32'h7FFF_FFFF);
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_pend = rise || (m_pend && !took_irq);
            irq_hist.push_back(irq);
            if (irq_hist.size() > 8) void'(irq_hist.pop_front());
        end
    end

    // Compare every output against the model once per cycle.
    initial begin
        bit          want_exc;
        bit          want_irq;
        forever begin
            @(negedge clk);
            if (model_ready) begin
                want_exc = !reset && !stall && illop;
                want_irq = !reset && !stall && !illop && m_pend && m_pc[31] == 1'b0;
                checkOutput("model_pc", pc, m_pc);
                checkOutput("model_pc_plus4", pc_plus4, m_pc + 32'd4);
                checkOutput("model_irq_pend", {31'd0, irq_pend}, {31'd0, m_pend});
                checkOutput("model_epc_we", {31'd0, epc_we}, {31'd0, want_exc || want_irq});
                checkOutput("model_epc", epc, want_irq ? m_pc : m_pc + 32'd4);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        irq   = 1'b0;
        applyStimulus(0, PC_SRC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 0);
        tick(2);
        checkOutput("reset_pc", pc, 32'h8000_0000);
        checkOutput("reset_pc_plus4", pc_plus4, 32'h8000_0004);
        checkOutput("reset_pend", {31'd0, irq_pend}, 32'd0);
        checkOutput("reset_epc_we", {31'd0, epc_we}, 32'd0);

        // sequential fetch out of reset
        reset = 1'b0;
        tick(1); checkOutput("seq1", pc, 32'h8000_0004);
        tick(1); checkOutput("seq2", pc, 32'h8000_0008);
        tick(1); checkOutput("seq3", pc, 32'h8000_000C);
        tick(1); checkOutput("seq4", pc, 32'h8000_0010);

        // kernel JR drops to user space
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_2000, 0);
        tick(1); checkOutput("jr_kernel_to_user", pc, 32'h0000_2000);
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0040, 0);
        tick(1); checkOutput("jr_user", pc, 32'h0000_0040);
        // user JR cannot set bit 31
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h8000_1000, 0);
        tick(1); checkOutput("jr_user_masked", pc, 32'h0000_1000);

        // branches around pc=0x100
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0100, 0);
        tick(1); checkOutput("to_0x100", pc, 32'h0000_0100);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        #1; checkOutput("link_value", pc_plus4, 32'h0000_0104);
        tick(1); checkOutput("branch_taken_back", pc, 32'h0000_0100);
        applyStimulus(0, PC_SRC_BRANCH, 0, 16'hFFFF, 26'h0, 32'h0, 0);
        tick(1); checkOutput("branch_not_taken", pc, 32'h0000_0104);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'h0010, 26'h0, 32'h0, 0);
        tick(1); checkOutput("branch_forward", pc, 32'h0000_0148);
        applyStimulus(0, PC_SRC_JUMP, 0, 16'h0000, 26'h0000123, 32'h0, 0);
        tick(1); checkOutput("jump_user", pc, 32'h0000_048C);
        applyStimulus(0, 3'd5, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        tick(1); checkOutput("unknown_src_as_seq", pc, 32'h0000_0490);

        // user-mode interrupt at pc=0x200 (branch-to-self keeps pc fixed)
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0200, 0);
        tick(1);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        irq = 1'b1;
        tick(2); checkOutput("irq_latency_2", {31'd0, irq_pend}, 32'd0);
        tick(1); checkOutput("irq_latency_3", {31'd0, irq_pend}, 32'd1);
        checkOutput("irq_pc_before_trap", pc, 32'h0000_0200);
        #1;
        checkOutput("irq_epc_we", {31'd0, epc_we}, 32'd1);
        checkOutput("irq_epc", epc, 32'h0000_0200);
        tick(1);
        checkOutput("irq_vector", pc, 32'h8000_0004);
        checkOutput("irq_pend_cleared", {31'd0, irq_pend}, 32'd0);

        // same again while stalled
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0200, 0);
        irq = 1'b0;
        tick(1);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        tick(3);
        applyStimulus(1, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        irq = 1'b1;
        tick(5);
        checkOutput("stall_pc_hold", pc, 32'h0000_0200);
        checkOutput("stall_pend_held", {31'd0, irq_pend}, 32'd1);
        checkOutput("stall_no_trap", {31'd0, epc_we}, 32'd0);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        #1; checkOutput("unstall_epc_we", {31'd0, epc_we}, 32'd1);
        tick(1); checkOutput("unstall_vector", pc, 32'h8000_0004);

        // kernel masks interrupts until JR to user space
        applyStimulus(0, PC_SRC_JUMP, 0, 16'h0000, 26'h0000040, 32'h0, 0);
        tick(1); checkOutput("jump_kernel", pc, 32'h8000_0100);
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        irq = 1'b0;
        tick(3);
        irq = 1'b1;
        tick(5);
        checkOutput("kernel_masked_pc", pc, 32'h8000_0100);
        checkOutput("kernel_masked_pend", {31'd0, irq_pend}, 32'd1);
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0300, 0);
        tick(1); checkOutput("kernel_jr_user", pc, 32'h0000_0300);
        #1; checkOutput("user_irq_epc", epc, 32'h0000_0300);
        tick(1); checkOutput("user_irq_taken", pc, 32'h8000_0004);

        // illegal op with interrupt pending: exception wins
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        irq = 1'b0;
        tick(3);
        irq = 1'b1;
        tick(2);
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0080, 0);
        tick(1);
        checkOutput("illop_setup_pc", pc, 32'h0000_0080);
        checkOutput("illop_setup_pend", {31'd0, irq_pend}, 32'd1);
        applyStimulus(0, PC_SRC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 1);
        #1;
        checkOutput("illop_epc_we", {31'd0, epc_we}, 32'd1);
        checkOutput("illop_epc", epc, 32'h0000_0084);
        tick(1);
        checkOutput("illop_vector", pc, 32'h8000_0008);
        checkOutput("illop_pend_kept", {31'd0, irq_pend}, 32'd1);
        applyStimulus(0, PC_SRC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 0);
        tick(1); checkOutput("handler_seq", pc, 32'h8000_000C);
        applyStimulus(0, PC_SRC_JR, 0, 16'h0000, 26'h0, 32'h0000_0084, 0);
        tick(1); checkOutput("eret_user", pc, 32'h0000_0084);
        tick(1);
        checkOutput("deferred_irq", pc, 32'h8000_0004);
        checkOutput("deferred_irq_clear", {31'd0, irq_pend}, 32'd0);

        // asynchronous reset in the middle of a cycle
        applyStimulus(0, PC_SRC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 0);
        irq = 1'b0;
        tick(3);
        irq = 1'b1;
        tick(3);
        checkOutput("pre_reset_pend", {31'd0, irq_pend}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_pc", pc, 32'h8000_0000);
        checkOutput("async_reset_pend", {31'd0, irq_pend}, 32'd0);
        tick(1);
        reset = 1'b0;
        applyStimulus(0, PC_SRC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 0);
        tick(1); checkOutput("post_reset_fetch", pc, 32'h8000_0004);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
